regfile_multiport: RTL
======================

// Module: regfile_multiport
// PURPOSE
//  Parametrised register file: DEPTH x DATA_W storage, NUM_RD synchronous read ports, one write port, one debug read port.
//  Sits in the decode stage of the pipelined MIPS datapath and replaces the fixed 32x32 two-read-port file.
//  Adds write-first bypass, registered reads, and a hardware clear sequencer.
//  The clear sequencer runs after reset and on request, so the storage array carries no reset and stays RAM-inferable.
// PARAMETERS
//  DATA_W    32  data width of each entry
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is an ordinary register
// PORTS
//  clock        in   1               single clock; all state updates on posedge
//  reset_n      in   1               asynchronous assert, active-low reset
//  rd_addr      in   NUM_RD*ADDR_W   read addresses; port k uses slice [k*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_RD*DATA_W   registered read data, port k in slice [k*DATA_W +: DATA_W]
//  wr_en        in   1               write strobe
//  wr_addr      in   ADDR_W          write address
//  wr_data      in   DATA_W          write data
//  clr_req      in   1               single-cycle pulse: start a full clear
//  busy         out  1               high while the clear sequencer runs
//  wr_drop      out  1               1-cycle pulse: a write was discarded because busy was high
//  dbg_addr     in   ADDR_W          debug read address
//  dbg_data     out  DATA_W          registered debug read data
//  parity_err   out  1               parity error pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous): rd_data=0, dbg_data=0, wr_drop=0, parity_err=0, busy=1, state=CLEAR, clr_cnt=0.
//  FSM has two states, IDLE and CLEAR.
//   CLEAR: each cycle writes 0 to entry clr_cnt, then clr_cnt++.
//   CLEAR -> IDLE at the cycle that writes entry DEPTH-1. busy is low from the next cycle.
//   CLEAR therefore lasts exactly DEPTH cycles.
//   IDLE -> CLEAR on clr_req=1. clr_req is ignored while already in CLEAR (no restart).
//  Write (IDLE, wr_en=1): entry wr_addr takes wr_data at posedge.
//   With ZERO_REG=1, a write to address 0 is silently ignored and wr_drop is NOT raised.
//  Write during CLEAR: discarded; wr_drop=1 on the following cycle.
//   A write coinciding with the IDLE->CLEAR transition cycle (clr_req=1) is also discarded.
//  Read latency is 1 cycle: rd_data[k] at cycle n+1 reflects rd_addr[k] sampled at cycle n.
//  Bypass is write-first: if wr_en is accepted and wr_addr==rd_addr[k], rd_data[k] at n+1 = wr_data.
//   Bypass does not apply to address 0 when ZERO_REG=1; that read returns 0.
//  Reads issued while busy=1 return 0. Independent ports may read the same address.
//  dbg_data: 1-cycle latency, same rules as a read port (including bypass), and also returns 0 while busy.
//  Reset asserted mid-clear restarts the clear at entry 0 after release.
//   Entries are not otherwise cleared by reset itself.
//  No arithmetic beyond clr_cnt. clr_cnt is ADDR_W+1 bits wide, so it can never wrap into a premature IDLE.
// CONFIGURATION
//  Macro REGFILE_PARITY_EN.
//  Defined:
//   Each entry stores DATA_W+1 bits; the extra bit is even parity of the written data. The clear sequencer writes parity 0.
//   Every read/debug port checks parity of the stored word.
//   parity_err pulses 1 in the same cycle the mismatching rd_data/dbg_data is presented.
//   Bypassed reads are not checked.
//  Undefined: storage is DATA_W bits and parity_err is tied to 0.
// STRUCTURE
//  regfile_pkg holds:
//   state encoding (ST_IDLE=1'b0, ST_CLEAR=1'b1)
//   the NUM_RD limit constant
//   the even-parity function used under REGFILE_PARITY_EN
//  Sub-module regfile_clear_seq: the FSM plus clr_cnt.
//   Outputs: busy, clr_we, clr_addr.
//   The top level muxes clr_we/clr_addr/0 into the write port ahead of the array.
//  Read ports are generated with a generate loop over NUM_RD.
// TESTING
//  Reset then idle: busy=1 for exactly 32 cycles, then 0; read every address -> all 0.
//  Write 0xDEADBEEF to r5, read r5 next cycle on both ports -> 0xDEADBEEF one cycle after address.
//  Same cycle: wr r7=0x12345678, rd_addr0=7 -> rd_data0=0x12345678 next cycle (bypass).
//  ZERO_REG=1: wr r0=0xFFFFFFFF -> read r0 returns 0, wr_drop stays 0.
//  clr_req with r3=0xA5A5A5A5, write r4 during clear:
//   -> wr_drop pulses, busy for 32 cycles, r3 and r4 both read 0 afterwards.
//  REGFILE_PARITY_EN: force flip one stored bit of r9, read r9 -> parity_err=1 with the data.
//   Without the macro parity_err stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: clear-sequencer state
// encoding, read-port limit, and the even-parity helper used when
// REGFILE_PARITY_EN is defined.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Upper bound on the number of normal read ports (debug port not counted)
    localparam int RD_PORTS_MAX = 4;

    // Widest data word the parity helper accepts; narrower words are zero-padded
    localparam int PARITY_MAX_W = 64;

    // Even parity: the returned bit makes the total count of ones even
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry writing zero, after reset and on clr_req.
// Latency: busy rises the cycle after clr_req, and stays high for exactly 2**ADDR_W cycles.
// Backpressure: clr_req is ignored while a clear is already running (no restart).
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int              DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

    clr_state_t      state, state_nxt;
    // One bit wider than the address so the counter can never wrap back to 0
    logic [ADDR_W:0] clr_cnt, clr_cnt_nxt;

    // State register: reset lands in CLEAR at entry 0 so storage needs no reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state: leave CLEAR on the cycle that writes the last entry
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_nxt = clr_cnt + ONE;
                if (clr_cnt == LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs: one zero-write per cycle while clearing
    always_comb begin
        busy     = (state == ST_CLEAR);
        clr_we   = (state == ST_CLEAR);
        clr_addr = clr_cnt[ADDR_W-1:0];
    end

endmodule

// File: rtl/regfile_multiport.sv
// Register file: DEPTH x DATA_W, NUM_RD registered read ports plus a debug port, write-first bypass; optional parity via REGFILE_PARITY_EN.
// Latency: 1 cycle from address to rd_data/dbg_data; writes visible at the next posedge.
// Backpressure: while busy (clearing) writes are dropped with a wr_drop pulse and reads return 0.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_drop,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Debug port is handled as one extra read port at the top index
    localparam int NP    = NUM_RD + 1;
`ifdef REGFILE_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif

    if (NUM_RD < 1 || NUM_RD > RD_PORTS_MAX) begin : g_bad_num_rd
        $error("regfile_multiport: NUM_RD out of range");
    end

    logic [STORE_W-1:0]    mem [DEPTH];
    logic                  clr_we;
    logic [ADDR_W-1:0]     clr_addr;
    logic                  wr_zero;
    logic                  wr_acc;
    logic                  arr_we;
    logic [ADDR_W-1:0]     arr_addr;
    logic [DATA_W-1:0]     arr_dat;
    logic [STORE_W-1:0]    arr_word;
    logic [NP*ADDR_W-1:0]  port_addr;
    logic [NP*DATA_W-1:0]  port_data;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write acceptance: not while clearing, not on the cycle a clear starts, never to a hard-wired zero entry
    always_comb begin
        wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
        wr_acc  = wr_en && !busy && !clr_req && !wr_zero;
    end

    // Write-port mux: the clear sequencer owns the array while busy
    always_comb begin
        arr_we   = clr_we || wr_acc;
        arr_addr = clr_we ? clr_addr : wr_addr;
        arr_dat  = clr_we ? '0 : wr_data;
    end

`ifdef REGFILE_PARITY_EN
    logic [PARITY_MAX_W-1:0] par_pad;
    if (DATA_W > PARITY_MAX_W) begin : g_bad_data_w
        $error("regfile_multiport: DATA_W too wide for parity helper");
    end

    // Stored word carries even parity of its data; cleared words hold parity 0
    always_comb begin
        par_pad               = '0;
        par_pad[DATA_W-1:0]   = arr_dat;
        arr_word              = {even_parity(par_pad), arr_dat};
    end
`else
    // Stored word is the data alone
    always_comb begin
        arr_word = arr_dat;
    end
`endif

    // Storage array: no reset so it stays RAM-inferable
    always_ff @(posedge clock) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_word;
        end
    end

    // Dropped-write flag: any write seen while clearing or on the clear-start cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && (busy || clr_req);
        end
    end

    assign port_addr = {dbg_addr, rd_addr};

`ifdef REGFILE_PARITY_EN
    logic [NP-1:0] port_err;
`endif

    for (genvar k = 0; k < NP; k++) begin : g_port
        logic [ADDR_W-1:0]  addr;
        logic [STORE_W-1:0] word;
        logic               zero_hit;
        logic               byp;
        logic [DATA_W-1:0]  data_q;

        assign addr     = port_addr[k*ADDR_W +: ADDR_W];
        assign word     = mem[addr];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        assign byp      = wr_acc && (wr_addr == addr);

        // Registered read: zero while clearing or on entry 0, else write-first bypass, else array
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (busy || zero_hit) begin
                data_q <= '0;
            end else if (byp) begin
                data_q <= wr_data;
            end else begin
                data_q <= word[DATA_W-1:0];
            end
        end

        assign port_data[k*DATA_W +: DATA_W] = data_q;

`ifdef REGFILE_PARITY_EN
        logic err_q;
        // Parity check on array reads only, aligned with the data it flags
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                err_q <= 1'b0;
            end else begin
                err_q <= !busy && !zero_hit && !byp && (^word);
            end
        end
        assign port_err[k] = err_q;
`endif
    end

    assign rd_data  = port_data[NUM_RD*DATA_W-1:0];
    assign dbg_data = port_data[NUM_RD*DATA_W +: DATA_W];

`ifdef REGFILE_PARITY_EN
    assign parity_err = |port_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
